// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: read-modify-write pixel painter and full-screen clear
// engine for the 64x64 LED panel frame memory (two pixels per 24-bit word).
// Optional 2x2 brush painting is enabled by FB_PIXEL_WRITER_BRUSH2X2_EN.
module fb_pixel_writer #(
    parameter int NUM_COLS = 64,
    parameter int NUM_ROWS = 64,
    parameter int BPP      = 12,
    parameter int ADDR_W   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          px_valid,
    output logic                          px_ready,
    input  logic [$clog2(NUM_COLS)-1:0]   px_x,
    input  logic [$clog2(NUM_ROWS)-1:0]   px_y,
    input  logic [BPP-1:0]                px_color,
    input  logic                          clr_req,
    input  logic [BPP-1:0]                clr_color,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_rd,
    input  logic [2*BPP-1:0]              mem_rdata,
    output logic                          mem_we,
    output logic [2*BPP-1:0]              mem_wdata
);

    localparam int XW = $clog2(NUM_COLS);
    localparam int YW = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [BPP-1:0]      color_q, color_d;
    logic [BPP-1:0]      clr_color_q, clr_color_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic [XW-1:0]       cur_x;
    logic [YW-1:0]       cur_y;
    logic [ADDR_W-1:0]   pix_addr;

`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
    logic [1:0]          sub_q, sub_d;
    logic                brush_found;
    logic [1:0]          brush_nxt;

    // A sub-pixel is skipped when its +1 offset would leave the panel.
    function automatic logic sub_ok(input logic [1:0] s, input logic x_max, input logic y_max);
        return !(s[0] && x_max) && !(s[1] && y_max);
    endfunction

    // Current sub-pixel coordinate: bit0 offsets x, bit1 offsets y.
    always_comb begin
        cur_x = x_q + XW'(sub_q[0]);
        cur_y = y_q + YW'(sub_q[1]);
    end

    // Next unclipped sub-pixel after the current one, if any remains.
    always_comb begin
        brush_found = 1'b0;
        brush_nxt   = sub_q;
        for (int unsigned s = 1; s < 4; s++) begin
            if (!brush_found && s > 32'(sub_q) &&
                sub_ok(2'(s), x_q == '1, y_q == '1)) begin
                brush_found = 1'b1;
                brush_nxt   = 2'(s);
            end
        end
    end
`else
    // Single-pixel mode paints exactly the latched coordinate.
    always_comb begin
        cur_x = x_q;
        cur_y = y_q;
    end
`endif

    // Row pairs share a word: y[4:0] picks the word row, y[5] picks the field.
    assign pix_addr = {cur_y[YW-2:0], cur_x};

    // Next-state and output decode; outputs are forced quiet while in reset.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        color_d     = color_q;
        clr_color_d = clr_color_q;
        cnt_d       = cnt_q;
`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
        sub_d       = sub_q;
`endif
        px_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                px_ready = !clr_req;
                if (clr_req) begin
                    clr_color_d = clr_color;
                    cnt_d       = '0;
                    state_d     = CLR;
                end else if (px_valid) begin
                    x_d     = px_x;
                    y_d     = px_y;
                    color_d = px_color;
`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
                    sub_d   = '0;
`endif
                    state_d = RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = pix_addr;
                state_d  = WR;
            end
            WR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = pix_addr;
                mem_wdata = cur_y[YW-1] ? {mem_rdata[2*BPP-1:BPP], color_q}
                                        : {color_q, mem_rdata[BPP-1:0]};
`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
                if (brush_found) begin
                    sub_d   = brush_nxt;
                    state_d = RD;
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`else
                done    = 1'b1;
                state_d = IDLE;
`endif
            end
            CLR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = {clr_color_q, clr_color_q};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            px_ready  = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            mem_rd    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            color_q     <= '0;
            clr_color_q <= '0;
            cnt_q       <= '0;
`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
            sub_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            clr_color_q <= clr_color_d;
            cnt_q       <= cnt_d;
`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
            sub_q       <= sub_d;
`endif
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: reset, pixel RMW in both halves,
// corner pixel, full clear, reset during clear, and 2x2 brush clipping.
module tb_fb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        px_valid;
    logic        px_ready;
    logic [5:0]  px_x;
    logic [5:0]  px_y;
    logic [11:0] px_color;
    logic        clr_req;
    logic [11:0] clr_color;
    logic        busy;
    logic        done;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic [23:0] mem_rdata;
    logic        mem_we;
    logic [23:0] mem_wdata;

    int n_chk = 0;
    int n_bad = 0;

`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
    localparam bit BRUSH = 1'b1;
`else
    localparam bit BRUSH = 1'b0;
`endif

    fb_pixel_writer #(.NUM_COLS(64), .NUM_ROWS(64), .BPP(12), .ADDR_W(11)) dut (
        .clk(clk), .rst(rst),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_color(px_color),
        .clr_req(clr_req), .clr_color(clr_color),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel request; checks the RD and first WR cycle, then drains.
    task automatic pixel(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c,
                         input logic [23:0] rd, input logic [10:0] ea,
                         input logic [23:0] ew, input logic ed, input string tag);
        px_valid = 1'b1; px_x = x; px_y = y; px_color = c; mem_rdata = rd;
        chk({tag, "_ready"}, 32'(px_ready), 32'd1);
        tick();
        px_valid = 1'b0; px_x = ~x; px_y = ~y; px_color = ~c;
        chk({tag, "_rd"},    32'(mem_rd),   32'd1);
        chk({tag, "_rdwe"},  32'(mem_we),   32'd0);
        chk({tag, "_raddr"}, 32'(mem_addr), 32'(ea));
        chk({tag, "_rbusy"}, 32'(busy),     32'd1);
        chk({tag, "_rrdy"},  32'(px_ready), 32'd0);
        tick();
        chk({tag, "_we"},    32'(mem_we),    32'd1);
        chk({tag, "_wrrd"},  32'(mem_rd),    32'd0);
        chk({tag, "_waddr"}, 32'(mem_addr),  32'(ea));
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'(ew));
        chk({tag, "_done"},  32'(done),      32'(ed));
        tick();
        for (int i = 0; i < 8 && busy; i++) tick();
        chk({tag, "_idle"},  32'(busy),     32'd0);
        chk({tag, "_again"}, 32'(px_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; px_valid = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        clr_req = 1'b0; clr_color = '0; mem_rdata = '0;
        tick();
        chk("rst_ready", 32'(px_ready),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_rd",    32'(mem_rd),    32'd0);
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_busy",  32'(busy),     32'd0);
        chk("idle_ready", 32'(px_ready), 32'd1);
        chk("idle_we",    32'(mem_we),   32'd0);

        pixel(6'd5,  6'd3,  12'hF00, 24'h123456, 11'h0C5, 24'hF00456, !BRUSH, "px_up");
        pixel(6'd5,  6'd35, 12'h0A0, 24'h123456, 11'h0C5, 24'h1230A0, !BRUSH, "px_lo");
        pixel(6'd63, 6'd63, 12'h123, 24'hABCDEF, 11'h7FF, 24'hABC123, 1'b1,   "px_corner");

        // Clear with a competing pixel request in the same cycle.
        clr_req = 1'b1; clr_color = 12'h00F; px_valid = 1'b1; px_x = 6'd1; px_y = 6'd1;
        #1;
        chk("clr_ready", 32'(px_ready), 32'd0);
        tick();
        clr_req = 1'b0; px_valid = 1'b0; clr_color = 12'hFFF;
        for (int i = 0; i < 2048; i++) begin
            chk("clr_we",    32'(mem_we),    32'd1);
            chk("clr_rd",    32'(mem_rd),    32'd0);
            chk("clr_addr",  32'(mem_addr),  32'(i));
            chk("clr_wdata", 32'(mem_wdata), 32'h00F00F);
            chk("clr_done",  32'(done),      (i == 2047) ? 32'd1 : 32'd0);
            tick();
        end
        chk("clr_end_busy", 32'(busy),   32'd0);
        chk("clr_end_we",   32'(mem_we), 32'd0);
        chk("clr_end_rd",   32'(mem_rd), 32'd0);

        // Reset during the 100th clear write.
        clr_req = 1'b1; clr_color = 12'h0F0;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        chk("crst_addr99", 32'(mem_addr), 32'd99);
        rst = 1'b1;
        #1;
        chk("crst_we_in_rst", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("crst_busy",  32'(busy),     32'd0);
        chk("crst_we",    32'(mem_we),   32'd0);
        chk("crst_ready", 32'(px_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("crst_quiet", 32'(mem_we), 32'd0);
        end

`ifdef FB_PIXEL_WRITER_BRUSH2X2_EN
        // Brush at the right edge: only (63,10) and (63,11) are painted.
        px_valid = 1'b1; px_x = 6'd63; px_y = 6'd10; px_color = 12'h5A5; mem_rdata = '0;
        tick();
        px_valid = 1'b0;
        chk("br_rd1",   32'(mem_rd),    32'd1);
        chk("br_a1",    32'(mem_addr),  32'h2BF);
        tick();
        chk("br_we1",   32'(mem_we),    32'd1);
        chk("br_w1",    32'(mem_wdata), 32'h5A5000);
        chk("br_d1",    32'(done),      32'd0);
        tick();
        chk("br_rd2",   32'(mem_rd),    32'd1);
        chk("br_a2",    32'(mem_addr),  32'h2FF);
        tick();
        chk("br_we2",   32'(mem_we),    32'd1);
        chk("br_wa2",   32'(mem_addr),  32'h2FF);
        chk("br_d2",    32'(done),      32'd1);
        tick();
        chk("br_idle",  32'(busy),      32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
